// File: rtl/mem_if_pkg.sv
// Shared definitions for the native memory-bus initiator: FSM states,
// default bus widths, strobe constants and the queued command layout.
package mem_if_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  localparam logic [3:0] WSTRB_READ = 4'b0000;
  localparam logic [3:0] WSTRB_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Command record at the default widths; packed MSB-first as {instr, wstrb, wdata, addr}.
  typedef struct packed {
    logic                  instr;
    logic [3:0]            wstrb;
    logic [DATA_W_DEF-1:0] wdata;
    logic [ADDR_W_DEF-1:0] addr;
  } cmd_t;

  function automatic int cmd_width(input int addr_w, input int data_w);
    return 1 + 4 + data_w + addr_w;
  endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Native memory bus between an initiator (master) and a responder (slave).
interface mem_initiator_if
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              mem_valid;
  logic              mem_instr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        wstrb;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous command queue with first-word fall-through read data.
// Pointers carry one extra wrap bit to tell full from empty.
module cmd_fifo #(
  parameter int WIDTH = 53,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[PTR_W-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/mem_initiator.sv
// Bus master that issues queued commands one at a time on the native memory
// bus, holding each request until mem_ready or timeout, and returns a response.
module mem_initiator
  import mem_if_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255,
  parameter int GAP_CYCLES = 1,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  input  logic              cmd_instr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [15:0]       txn_count,
  output logic              err_sticky,
  mem_initiator_if.master   bus
);

  localparam int CMD_W = cmd_width(ADDR_W, DATA_W);
  localparam int TO_W  = $clog2(TIMEOUT + 2);
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t state, state_next;

  logic [CMD_W-1:0]  fifo_in, fifo_out;
  logic              fifo_full, fifo_empty;
  logic              pop, done, abort;
  logic [TO_W-1:0]   to_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              head_instr;
  logic [3:0]        head_wstrb;
  logic [DATA_W-1:0] head_wdata;
  logic [ADDR_W-1:0] head_addr;

  assign fifo_in = {cmd_instr, cmd_wstrb, cmd_wdata, cmd_addr};
  assign {head_instr, head_wstrb, head_wdata, head_addr} = fifo_out;

  cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .wdata (fifo_in),
    .pop   (pop),
    .rdata (fifo_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: if (!fifo_empty && !rsp_valid) begin
        pop        = 1'b1;
        state_next = REQ;
      end
      // mem_ready takes priority over a timeout expiring in the same cycle.
      REQ: if (bus.mem_ready) begin
        done       = 1'b1;
        state_next = GAP;
      end else if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
        abort      = 1'b1;
        state_next = GAP;
      end
      GAP: if (gap_cnt == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_valid = (state == REQ);
  assign cmd_ready     = !fifo_full;
  assign busy          = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset || done || abort) begin
      bus.mem_instr <= 1'b0;
      bus.wstrb     <= '0;
      bus.mem_wdata <= '0;
      bus.mem_addr  <= '0;
    end else if (pop) begin
      bus.mem_instr <= head_instr;
      bus.wstrb     <= head_wstrb;
      bus.mem_wdata <= head_wdata;
      bus.mem_addr  <= head_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || pop)           to_cnt <= '0;
    else if (state == REQ)      to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || state != GAP)  gap_cnt <= '0;
    else                        gap_cnt <= gap_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
      txn_count   <= '0;
      err_sticky  <= 1'b0;
    end else if (done) begin
      rsp_valid   <= 1'b1;
      rsp_rdata   <= bus.mem_rdata;
      rsp_timeout <= 1'b0;
      txn_count   <= txn_count + 1'b1;
    end else if (abort) begin
      rsp_valid   <= 1'b1;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b1;
      err_sticky  <= 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: a stimulus process queues expected bus
// requests and responses; a responder model and a response monitor check them.
module tb_mem_initiator;
  import mem_if_pkg::*;

  localparam int TIMEOUT_N = 8;
  localparam int GAP_N     = 1;
  localparam int DEPTH_N   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_instr = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        busy;
  logic [15:0] txn_count;
  logic        err_sticky;

  always #5 clk = ~clk;

  mem_initiator_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  mem_initiator #(
    .FIFO_DEPTH(DEPTH_N), .TIMEOUT(TIMEOUT_N), .GAP_CYCLES(GAP_N),
    .ADDR_W(16), .DATA_W(32)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_instr(cmd_instr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .busy(busy), .txn_count(txn_count),
    .err_sticky(err_sticky), .bus(bus)
  );

  typedef struct {
    cmd_t        cmd;
    int          vlen;    // cycles mem_valid must stay high
    logic [31:0] rdata;   // value driven on mem_rdata
    int          hold;    // extra cycles mem_ready stays high after completion
    bit          never;   // responder never asserts mem_ready
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        timeout;
  } rsp_t;

  req_t req_q[$];
  rsp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   starts = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic [15:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic instr, input int vlen,
                              input logic [31:0] rdata, input int hold, input bit never);
    req_t r;
    r.cmd   = '{instr: instr, wstrb: wstrb, wdata: wdata, addr: addr};
    r.vlen  = vlen;
    r.rdata = rdata;
    r.hold  = hold;
    r.never = never;
    return r;
  endfunction

  // Tasks are entered and left at posedge+#1.
  task automatic push(input req_t r, input logic [31:0] er, input logic et);
    rsp_t e;
    bit   ok;
    e.rdata   = er;
    e.timeout = et;
    req_q.push_back(r);
    exp_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_addr  = r.cmd.addr;
    cmd_wdata = r.cmd.wdata;
    cmd_wstrb = r.cmd.wstrb;
    cmd_instr = r.cmd.instr;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("cmd_accept_timeout", 1, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid && !bus.mem_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_idle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Responder model: checks each request against the queued expectation.
  initial begin
    req_t cur;
    int   n, hold_left, low_cnt;
    bit   in_xfer, seen;
    in_xfer = 0; seen = 0; n = 0; hold_left = 0; low_cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_xfer = 0; seen = 0; n = 0; hold_left = 0; low_cnt = 0;
        bus.mem_ready = 1'b0;
      end else if (in_xfer) begin
        if (bus.mem_valid) begin
          n++;
          check("req_addr_stable",  bus.mem_addr,  cur.cmd.addr);
          check("req_wdata_stable", bus.mem_wdata, cur.cmd.wdata);
          check("req_wstrb_stable", bus.wstrb,     cur.cmd.wstrb);
          check("req_instr_stable", bus.mem_instr, cur.cmd.instr);
          if (!cur.never && n == cur.vlen) bus.mem_ready = 1'b1;
        end else begin
          check("valid_cycles", n, cur.vlen);
          in_xfer = 0;
          low_cnt = 1;
          if (cur.hold == 0) bus.mem_ready = 1'b0;
          else hold_left = cur.hold - 1;
        end
      end else if (bus.mem_valid) begin
        if (seen) check("gap_low_cycles_ok", low_cnt >= GAP_N, 1);
        if (req_q.size() == 0) begin
          check("unexpected_request", 1, 0);
        end else begin
          cur = req_q.pop_front();
          in_xfer = 1; seen = 1; n = 1;
          starts++;
          bus.mem_rdata = cur.rdata;
          check("req_addr",  bus.mem_addr,  cur.cmd.addr);
          check("req_wdata", bus.mem_wdata, cur.cmd.wdata);
          check("req_wstrb", bus.wstrb,     cur.cmd.wstrb);
          check("req_instr", bus.mem_instr, cur.cmd.instr);
          if (!cur.never && cur.vlen == 1) bus.mem_ready = 1'b1;
        end
      end else begin
        low_cnt++;
        if (bus.mem_ready) begin
          if (hold_left == 0) bus.mem_ready = 1'b0;
          else hold_left--;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every response handshake.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_response", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata",   rsp_rdata,   e.rdata);
          check("rsp_timeout", rsp_timeout, e.timeout);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    cycles(3);
    @(negedge clk);
    reset = 1'b0;
    check("reset_cmd_ready",  cmd_ready,     1);
    check("reset_mem_valid",  bus.mem_valid, 0);
    check("reset_rsp_valid",  rsp_valid,     0);
    check("reset_busy",       busy,          0);
    check("reset_txn_count",  txn_count,     0);
    check("reset_err_sticky", err_sticky,    0);
    check("reset_mem_addr",   bus.mem_addr,  0);
    @(posedge clk); #1;

    // Single read, 3 cycles of mem_valid.
    push(mk(16'h0010, 32'h0, WSTRB_READ, 1'b1, 3, 32'h0000_0093, 0, 0), 32'h0000_0093, 1'b0);
    wait_idle();
    check("read_txn_count", txn_count, 1);

    // Write held stable across 5 REQ cycles.
    push(mk(16'h0200, 32'hDEAD_BEEF, WSTRB_WORD, 1'b0, 5, 32'h1234_5678, 0, 0), 32'h1234_5678, 1'b0);
    wait_idle();
    check("write_txn_count", txn_count, 2);

    // Queue full with response back-pressure.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(mk(16'h0300 + 16'(i), 32'h0, WSTRB_READ, 1'b0, 1 + (i % 2), 32'hA000_0000 + 32'(i), 0, 0),
           32'hA000_0000 + 32'(i), 1'b0);
    @(negedge clk);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_busy",      busy,      1);
    s0 = starts;
    cycles(10);
    check("backpressure_no_issue", starts, s0);
    check("backpressure_rsp_held", rsp_valid, 1);
    rsp_ready = 1'b1;
    push(mk(16'h0305, 32'h0, WSTRB_READ, 1'b0, 2, 32'hA000_0005, 0, 0), 32'hA000_0005, 1'b0);
    wait_idle();
    check("full_txn_count", txn_count, 8);

    // Timeout after 8 REQ cycles, then a normal command.
    push(mk(16'h0400, 32'h0, WSTRB_READ, 1'b0, TIMEOUT_N, 32'hFFFF_FFFF, 0, 1), 32'h0, 1'b1);
    push(mk(16'h0404, 32'h0, WSTRB_READ, 1'b0, 2, 32'h0000_0055, 0, 0), 32'h0000_0055, 1'b0);
    wait_idle();
    check("timeout_err_sticky", err_sticky, 1);
    check("timeout_txn_count",  txn_count,  9);

    // mem_ready held 3 cycles past completion.
    push(mk(16'h0500, 32'h0, WSTRB_READ, 1'b1, 2, 32'h0000_0077, 3, 0), 32'h0000_0077, 1'b0);
    wait_idle();
    check("held_ready_txn_count", txn_count, 10);

    // Reset during REQ with two commands still queued.
    for (int i = 0; i < 3; i++)
      push(mk(16'h0600 + 16'(i), 32'h0, WSTRB_READ, 1'b0, 6, 32'h0, 0, 1), 32'h0, 1'b1);
    @(negedge clk);
    check("pre_reset_in_req", bus.mem_valid, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    req_q.delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_mem_valid", bus.mem_valid, 0);
    check("mid_reset_cmd_ready", cmd_ready,     1);
    check("mid_reset_rsp_valid", rsp_valid,     0);
    check("mid_reset_txn_count", txn_count,     0);
    check("mid_reset_busy",      busy,          0);
    check("mid_reset_err",       err_sticky,    0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("in_reset_mem_valid", bus.mem_valid, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    push(mk(16'h0700, 32'h0, WSTRB_READ, 1'b0, 1, 32'h0000_00C3, 0, 0), 32'h0000_00C3, 1'b0);
    wait_idle();
    check("post_reset_txn_count", txn_count,    1);
    check("rsp_queue_drained",    exp_q.size(), 0);
    check("req_queue_drained",    req_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Initiator (master) end of the native memory interface that the chip drives today: mem_valid, mem_addr, mem_wdata, wstrb and mem_instr out; mem_ready and mem_rdata in.
- Takes queued transaction commands from the test sequencer and issues them one at a time, holding each request stable until mem_ready.
- Returns read data and a timeout flag per transaction.
- Uses: exercise the existing driver/responder without silicon, and act as a golden bus master in loopback benches.

Parameters:
- FIFO_DEPTH, 4, command queue entries (power of two, >=2).
- TIMEOUT, 255, cycles in REQ without mem_ready before abort; 0 disables timeout.
- GAP_CYCLES, 1, minimum cycles mem_valid stays low between transactions (>=1).
- ADDR_W, 16, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue not full.
- cmd_addr  in  ADDR_W  transaction address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  4  byte enables; 0 = read.
- cmd_instr  in  1  instruction-fetch qualifier.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  captured mem_rdata (0 on timeout).
- rsp_timeout  out  1  transaction aborted by timeout.
- busy  out  1  queue non-empty, or state not IDLE.
- txn_count  out  16  completed (non-timeout) transactions; wraps 0xFFFF->0.
- err_sticky  out  1  set on any timeout; cleared only by reset.
- mem_valid  out  1  request to responder.
- mem_instr  out  1  fetch qualifier.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_W  request write data.
- wstrb  out  4  request byte strobes.
- mem_ready  in  1  responder completion.
- mem_rdata  in  DATA_W  responder read data.

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. FIFO emptied, timeout and gap counters 0, state IDLE. A reset asserted mid-REQ drops mem_valid the next cycle; no response is produced.
- Command queue:
  - Write on cmd_valid && cmd_ready; cmd_ready = !full.
  - Simultaneous push and pop when full is not allowed, since cmd_ready is already 0.
  - Pointers wrap modulo FIFO_DEPTH.
- States:
  - IDLE: if FIFO non-empty and rsp_valid==0, pop the head, load it into the mem_* registers, go to REQ. mem_valid rises the cycle after the pop, i.e. 2 cycles after the cmd handshake into an empty, idle block.
  - REQ: mem_valid=1; mem_addr, mem_wdata, wstrb and mem_instr stay stable. Timeout counter increments every cycle in REQ.
    - mem_ready=1 sampled: capture mem_rdata into rsp_rdata, rsp_timeout=0, rsp_valid=1, txn_count+1, go to GAP.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1: rsp_rdata=0, rsp_timeout=1, rsp_valid=1, err_sticky=1, go to GAP.
    - mem_ready and timeout in the same cycle: mem_ready wins.
  - GAP: mem_valid=0 and mem_* data outputs cleared to 0. Hold GAP_CYCLES cycles, then go to IDLE.
- Completion timing: the transfer completes in cycle M where mem_valid && mem_ready. mem_valid is low and rsp_valid high from M+1.
- mem_ready outside REQ is ignored. The responder may keep mem_ready high across several cycles; exactly one completion is counted per request.
- Response slot:
  - rsp_valid clears on rsp_valid && rsp_ready.
  - No new request is issued while rsp_valid=1; this back-pressure is intended.
  - Back-to-back throughput is 1 transaction per (1 + responder latency + GAP_CYCLES + 1) cycles with rsp_ready tied high.
- wstrb != 0 is a write: rsp_rdata still captures mem_rdata (don't-care for the consumer).
- busy = (state!=IDLE) || !empty.

Decomposition:
- Shared package mem_if_pkg:
  - state encoding: IDLE, REQ, GAP;
  - ADDR_W and DATA_W defaults;
  - WSTRB_READ=4'b0000 and WSTRB_WORD=4'b1111 constants;
  - the command record layout {instr, wstrb, wdata, addr}.
- One sub-module, cmd_fifo: synchronous FIFO, width 1+4+DATA_W+ADDR_W, FIFO_DEPTH entries, full/empty flags, reset clears pointers.
- The FSM, counters and response register stay in mem_initiator.

Test Plan:
- Single read: push addr=0x0010, wstrb=0, instr=1; responder asserts mem_ready 3 cycles after mem_valid with rdata=0x00000093. Required: mem_valid stable for 3 cycles, then low; rsp_valid=1, rsp_rdata=0x00000093, rsp_timeout=0, txn_count=1.
- Write stability: push addr=0x0200, wdata=0xDEADBEEF, wstrb=0xF; responder delays mem_ready 5 cycles. Required: addr, wdata and wstrb unchanged on every REQ cycle; exactly one completion.
- Queue full: hold rsp_ready=0, push 6 commands. Required: cmd_ready=0 after 4 are queued plus 1 issued; no second mem_valid until rsp_ready pulses; all 5 accepted responses return in push order.
- Timeout: TIMEOUT=8, responder never readies. Required: mem_valid high exactly 8 cycles; rsp_timeout=1, rsp_rdata=0, err_sticky=1, txn_count unchanged; the next queued command then issues normally.
- Held mem_ready: the responder keeps mem_ready high for 3 cycles after completion. Required: mem_valid drops at M+1, at least GAP_CYCLES low cycles follow, txn_count increments once, no spurious response.
- Reset mid-REQ: assert reset during REQ with 2 commands queued. Required: next cycle mem_valid=0, cmd_ready=1, rsp_valid=0, txn_count=0, FIFO empty; no mem_valid while reset is held.
